// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and register-file constants
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xword_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_rport.sv
// rtl/regfile_rport.sv - one read port: enable, x0 and write-through bypass mux
module regfile_rport #(
    parameter int XLEN = 32
) (
    input  logic               re,
    input  cpu_pkg::reg_addr_t addr,
    input  logic [XLEN-1:0]    stored,
    input  logic               rd_we,
    input  cpu_pkg::reg_addr_t rd_addr,
    input  logic [XLEN-1:0]    rd_data,
    output logic [XLEN-1:0]    data
);
    import cpu_pkg::*;

    // Bypass lets ID see the WB value in the same cycle it is written.
    always_comb begin
        data = stored;
        if (!re || addr == REG_ZERO) begin
            data = '0;
        end else if (rd_we && rd_addr == addr) begin
            data = rd_data;
        end
    end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 integer register file, one write port, two bypassed read ports, debug read
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_we,
    input  cpu_pkg::reg_addr_t rd_addr,
    input  logic [XLEN-1:0]    rd_data,
    input  logic               rs1_re,
    input  cpu_pkg::reg_addr_t rs1_addr,
    output logic [XLEN-1:0]    rs1_data,
    input  logic               rs2_re,
    input  cpu_pkg::reg_addr_t rs2_addr,
    output logic [XLEN-1:0]    rs2_data,
    input  cpu_pkg::reg_addr_t dbg_addr,
    output logic [XLEN-1:0]    dbg_data
);
    import cpu_pkg::*;

    // x0 has no storage; index 0 is never touched.
    logic [XLEN-1:0] regs [1:NREG-1];
    logic [XLEN-1:0] rs1_stored;
    logic [XLEN-1:0] rs2_stored;

    function automatic logic [XLEN-1:0] peek(input reg_addr_t a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != REG_ZERO && int'(a) < NREG) begin
            v = regs[a];
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (rd_we && rd_addr != REG_ZERO && int'(rd_addr) < NREG) begin
            regs[rd_addr] <= rd_data;
        end
    end

    always_comb begin
        rs1_stored = peek(rs1_addr);
        rs2_stored = peek(rs2_addr);
        dbg_data   = peek(dbg_addr);
    end

    regfile_rport #(.XLEN(XLEN)) u_rport1 (
        .re      (rs1_re),
        .addr    (rs1_addr),
        .stored  (rs1_stored),
        .rd_we   (rd_we),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .data    (rs1_data)
    );

    regfile_rport #(.XLEN(XLEN)) u_rport2 (
        .re      (rs2_re),
        .addr    (rs2_addr),
        .stored  (rs2_stored),
        .rd_we   (rd_we),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .data    (rs2_data)
    );

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - vector-table bench for regfile
`timescale 1ns/100ps
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rs1_re;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic        rs2_re;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .rd_we    (rd_we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_re   (rs1_re),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_re   (rs2_re),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  a1;
        logic        re2;
        logic [4:0]  a2;
        logic [4:0]  ad;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic re1, input logic [4:0] a1,
                                input logic re2, input logic [4:0] a2, input logic [4:0] ad,
                                input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ed);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.re1 = re1; v.a1 = a1; v.re2 = re2; v.a2 = a2; v.ad = ad;
        v.e1 = e1; v.e2 = e2; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        //             we  wa  wd            re1 a1 re2 a2  ad  e1            e2            ed
        vecs[0]  = mk(0,  0, 32'h0,        1,  5, 1,  7,  5, 32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(1,  5, 32'hDEADBEEF, 1,  5, 1,  0,  5, 32'hDEADBEEF, 32'h0,        32'h0);
        vecs[2]  = mk(0,  0, 32'h0,        1,  5, 1,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[3]  = mk(1,  7, 32'h12345678, 1,  7, 1,  7,  7, 32'h12345678, 32'h12345678, 32'h0);
        vecs[4]  = mk(1,  0, 32'hFFFFFFFF, 1,  0, 1,  7,  0, 32'h0,        32'h12345678, 32'h0);
        vecs[5]  = mk(0,  0, 32'hFFFFFFFF, 1,  0, 1,  7,  7, 32'h0,        32'h12345678, 32'h12345678);
        vecs[6]  = mk(1,  9, 32'hA5A5A5A5, 1,  9, 0,  9,  9, 32'hA5A5A5A5, 32'h0,        32'h0);
        vecs[7]  = mk(0,  9, 32'h11111111, 1,  9, 0,  9,  9, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5);
        vecs[8]  = mk(1,  1, 32'h1,        1,  1, 1,  5,  1, 32'h1,        32'hDEADBEEF, 32'h0);
        vecs[9]  = mk(1,  1, 32'h2,        1,  1, 1,  1,  1, 32'h2,        32'h2,        32'h1);
        vecs[10] = mk(1,  1, 32'h3,        1,  1, 1,  9,  1, 32'h3,        32'hA5A5A5A5, 32'h2);
        vecs[11] = mk(0,  0, 32'h0,        1,  1, 1,  7,  1, 32'h3,        32'h12345678, 32'h3);
        vecs[12] = mk(1, 31, 32'hCAFEF00D, 1, 31, 1, 30, 31, 32'hCAFEF00D, 32'h0,        32'h0);
        vecs[13] = mk(0,  0, 32'h0,        1, 31, 0, 31, 31, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D);

        rst = 1'b1; rd_we = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_re = 1'b1; rs1_addr = '0; rs2_re = 1'b1; rs2_addr = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // After reset every register reads zero on every port.
        for (int a = 1; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(a); dbg_addr = 5'(a);
            #1;
            check($sformatf("reset rs1 x%0d", a), rs1_data, 32'h0);
            check($sformatf("reset rs2 x%0d", a), rs2_data, 32'h0);
            check($sformatf("reset dbg x%0d", a), dbg_data, 32'h0);
        end

        // One vector per cycle: drive after negedge, sample before the posedge commits it.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rd_we = vecs[i].we; rd_addr = vecs[i].wa; rd_data = vecs[i].wd;
            rs1_re = vecs[i].re1; rs1_addr = vecs[i].a1;
            rs2_re = vecs[i].re2; rs2_addr = vecs[i].a2;
            dbg_addr = vecs[i].ad;
            #1;
            check($sformatf("vec%0d rs1", i), rs1_data, vecs[i].e1);
            check($sformatf("vec%0d rs2", i), rs2_data, vecs[i].e2);
            check($sformatf("vec%0d dbg", i), dbg_data, vecs[i].ed);
        end

        // Asynchronous reset clears storage before any clock edge.
        @(negedge clk);
        rd_we = 1'b0; rs1_re = 1'b1; rs2_re = 1'b1;
        rst = 1'b1;
        #0.5;
        dbg_addr = 5'd1;  rs1_addr = 5'd5;  rs2_addr = 5'd7;  #0.5;
        check("async dbg x1", dbg_data, 32'h0);
        check("async rs1 x5", rs1_data, 32'h0);
        check("async rs2 x7", rs2_data, 32'h0);
        dbg_addr = 5'd9;  rs1_addr = 5'd31; rs2_addr = 5'd9;  #0.5;
        check("async dbg x9", dbg_data, 32'h0);
        check("async rs1 x31", rs1_data, 32'h0);
        check("async rs2 x9", rs2_data, 32'h0);

        // A write presented while reset is held is dropped.
        rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rd_we = 1'b0;
        dbg_addr = 5'd3; rs1_addr = 5'd3;
        #1;
        check("rst write dbg x3", dbg_data, 32'h0);
        check("rst write rs1 x3", rs1_data, 32'h0);

        // First edge with reset low accepts a write.
        rd_we = 1'b1; rd_data = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        rd_we = 1'b0;
        #1;
        check("post-rst dbg x3", dbg_data, 32'h00000055);
        check("post-rst rs1 x3", rs1_data, 32'h00000055);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
